uart_tx_engine: RTL



---
 rtl/uart_tx_engine.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit engine: takes one byte per valid/ready handshake and
// shifts it out as start bit, LSB-first data, optional parity bit and
// 1 or 2 stop bits. Bit timing is 16 baud_x16_tick pulses per bit.
module uart_tx_engine #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_x16_tick,
    input  logic       tx_in_valid,
    output logic       tx_in_ready,
    input  logic [7:0] tx_in_data,
    output logic       uart_tx,
    output logic       tx_busy
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q,  state_d;
    logic [DATA_BITS-1:0] shift_q,  shift_d;
    logic [3:0]           tick_q,   tick_d;
    logic [2:0]           bit_q,    bit_d;
    logic                 parity_q, parity_d;
    logic                 line_q,   line_d;
    logic                 ready_q,  ready_d;
    logic                 busy_q,   busy_d;
    logic                 bit_end;

    // Next-state, datapath and registered-output computation.
    // Outputs are derived from the next state so that uart_tx, tx_in_ready
    // and tx_busy all change on the same edge as the state itself.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        tick_d   = tick_q;
        bit_d    = bit_q;
        parity_d = parity_q;
        bit_end  = baud_x16_tick && (tick_q == 4'd15);

        if (state_q != S_IDLE && baud_x16_tick) begin
            tick_d = tick_q + 4'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (tx_in_valid && ready_q) begin
                    shift_d  = tx_in_data[DATA_BITS-1:0];
                    tick_d   = '0;
                    bit_d    = '0;
                    parity_d = (^tx_in_data[DATA_BITS-1:0]) ^ PARITY_ODD;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = PARITY_EN ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = shift_d[0];
            S_PARITY: line_d = parity_d;
            default:  line_d = 1'b1;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
    end

    // State, datapath and output registers; reset forces the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            tick_q   <= '0;
            bit_q    <= '0;
            parity_q <= 1'b0;
            line_q   <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            tick_q   <= tick_d;
            bit_q    <= bit_d;
            parity_q <= parity_d;
            line_q   <= line_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign uart_tx     = line_q;
    assign tx_in_ready = ready_q;
    assign tx_busy     = busy_q;

endmodule
